// File: rtl/pwm_pkg.sv
// pwm_pkg: shared word width, word typedef and channel-index width helper for the PWM blocks.
package pwm_pkg;
  localparam int CNT_W_DEF = 16;
  typedef logic [CNT_W_DEF-1:0] pwm_word_t;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_deadband.sv
// pwm_deadband: splits one raw PWM into a complementary pair with dead time on every raw edge.
// Present only when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadband #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_act,
  input  logic            i_raw,
  input  logic [DT_W-1:0] i_dead_time,
  output logic            o_p,
  output logic            o_n
);
  logic            r_last, r_p, r_n;
  logic [DT_W-1:0] r_dcnt;
  logic            w_edge, w_dead;
  assign w_edge = i_raw != r_last;
  // The edge cycle itself is the first dead cycle, so the counter holds the remaining dead_time-1.
  assign w_dead = w_edge ? (i_dead_time != '0) : (r_dcnt != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b0;
      r_dcnt <= '0;
      r_p    <= 1'b0;
      r_n    <= 1'b0;
    end else if (!i_act) begin
      r_last <= 1'b0;
      r_dcnt <= '0;
      r_p    <= 1'b0;
      r_n    <= 1'b0;
    end else begin
      r_last <= i_raw;
      r_dcnt <= w_edge ? ((i_dead_time == '0) ? '0 : i_dead_time - 1'b1) :
                         ((r_dcnt == '0) ? '0 : r_dcnt - 1'b1);
      r_p    <= i_raw & ~w_dead;
      r_n    <= ~i_raw & ~w_dead;
    end
  end
  assign o_p = r_p;
  assign o_n = r_n;
endmodule
`endif

// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH edge-aligned PWM outputs on one shared period counter, double-buffered period/duty.
// Define PWM_DEADTIME_EN to generate complementary outputs with dead-time insertion.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEF_PERIOD = 1000,
  parameter int DT_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        period_wr,
  input  logic [CNT_W-1:0]            period_in,
  input  logic                        duty_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0] duty_ch,
  input  logic [CNT_W-1:0]            duty_in,
  input  logic [DT_W-1:0]             dead_time,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic [NUM_CH-1:0]           pwm_out_n,
  output logic                        period_tick
);
  logic [CNT_W-1:0]  r_cnt, r_per_act, r_per_pend;
  logic [CNT_W-1:0]  r_duty_act  [NUM_CH];
  logic [CNT_W-1:0]  r_duty_pend [NUM_CH];
  logic              r_tick;
  logic              w_run, w_wrap, w_load;
  logic [NUM_CH-1:0] w_pwm_d;
  assign w_run  = en && (r_per_act != '0);
  assign w_wrap = w_run && (r_cnt == r_per_act - 1'b1);
  // While idle, active keeps tracking pending so a restart uses the newest values.
  assign w_load = !w_run || w_wrap;
  always_comb begin
    w_pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) w_pwm_d[i] = w_run && (r_cnt < r_duty_act[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_per_act   <= CNT_W'(DEF_PERIOD);
      r_per_pend  <= CNT_W'(DEF_PERIOD);
      r_duty_act  <= '{default: '0};
      r_duty_pend <= '{default: '0};
      r_tick      <= 1'b0;
    end else begin
      r_cnt  <= w_load ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
      if (w_load) begin
        r_per_act  <= r_per_pend;
        r_duty_act <= r_duty_pend;
      end
      if (period_wr) r_per_pend <= period_in;
      if (duty_wr && (32'(duty_ch) < NUM_CH)) r_duty_pend[duty_ch] <= duty_in;
    end
  end
  assign period_tick = r_tick;
`ifdef PWM_DEADTIME_EN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_db
    pwm_deadband #(.DT_W(DT_W)) u_db (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_act       (w_run),
      .i_raw       (w_pwm_d[g]),
      .i_dead_time (dead_time),
      .o_p         (pwm_out[g]),
      .o_n         (pwm_out_n[g])
    );
  end
`else
  logic [NUM_CH-1:0] r_pwm;
  logic              w_unused_dt;
  assign w_unused_dt = ^dead_time;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= '0;
    else        r_pwm <= w_pwm_d;
  end
  assign pwm_out   = r_pwm;
  assign pwm_out_n = '0;
`endif
endmodule
